dac_sample_feeder: RTL and testbench
====================================

# dac_sample_feeder

Downstream consumer of the JTAG AXI-Lite write port: takes each completed write (address + data word) and either pushes a 16-bit sample into an internal FIFO or reprograms the sample-rate divider. A programmable tick drains one sample per sample period toward the MASH 1-1 modulator. Underflows and overflows are absorbed deterministically and counted, so the modulator always sees a continuous sample stream.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in samples; power of two, 4..256.
- SAMPLE_ADDR, 32'h0: write address that pushes a sample.
- DIV_ADDR, 32'h4: write address that loads the divider.
- DIV_RESET, 100: divider value after reset, in clock cycles per sample.

Ports (one clock; reset is synchronous and active-high):
- aclk, input, 1: system clock, shared with the AXI-Lite slave.
- areset, input, 1: synchronous, active-high reset.
- wr_valid, input, 1: single-cycle strobe; a completed write is present on wr_addr and wr_data.
- wr_addr, input, 32: write address.
- wr_data, input, 32: write data. Bits [15:0] carry the sample (two's complement). Bits [31:16] are ignored for sample writes.
- sample_out, output, 16: current sample to the modulator.
- sample_valid, output, 1: one-cycle pulse per sample period.
- fifo_level, output, $clog2(DEPTH)+1: current FIFO occupancy.
- underflow_cnt, output, 16: ticks that found the FIFO empty; saturates at 16'hFFFF.
- overflow_cnt, output, 16: pushes dropped because the FIFO was full; saturates at 16'hFFFF.
- div_value, output, 32: active divider value.

## Operation
- Write decode, acting only when wr_valid=1:
  - wr_addr==SAMPLE_ADDR: push wr_data[15:0].
  - wr_addr==DIV_ADDR: div_value <= max(wr_data, 2) and the tick counter clears to 0.
  - Any other address is ignored.
- Tick counter: counts 0..div_value-1 and wraps. tick=1 in the cycle where the count equals div_value-1.
- On tick with FIFO non-empty: pop the head; sample_out <= head; sample_valid <= 1.
- On tick with FIFO empty: sample_out holds its last value; sample_valid <= 1; underflow_cnt increments (saturating).
- Push with FIFO full and no simultaneous pop: the sample is dropped; overflow_cnt increments (saturating).
- Push and pop in the same cycle with FIFO full: both take effect; the level is unchanged; no overflow is counted.
- Push and tick in the same cycle with FIFO empty: no bypass. An underflow is counted, and the pushed sample is stored (level becomes 1).
- A divider write in the same cycle as a tick: the tick still pops, and the counter restarts at 0.
- FIFO read and write pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.

## Timing
- Reset values: sample_out=0, sample_valid=0, fifo_level=0, underflow_cnt=0, overflow_cnt=0, div_value=DIV_RESET, tick counter=0. FIFO contents are don't-care.
- areset asserted mid-operation discards all FIFO contents in one cycle. The first tick after release occurs DIV_RESET cycles later.
- Push latency: a wr_valid at edge N is reflected in fifo_level after edge N+1.
- Pop latency: a tick at cycle N produces sample_out and sample_valid registered at edge N+1. sample_valid is high for exactly one cycle.
- Consecutive sample_valid pulses are exactly div_value cycles apart while the divider is unchanged.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package dac_feed_pkg holds:
  - SAMPLE_W=16.
  - The default SAMPLE_ADDR and DIV_ADDR constants.
  - DIV_MIN=2.
  - A sample_t typedef (logic signed [15:0]).
- Sub-module sync_fifo (parameterised width and depth, registered level, full/empty flags) provides the sample storage.
- The divider, write decode and counters live in the top module.

## Test plan
- Reset then idle, DIV_RESET=100: sample_valid pulses every 100 cycles; sample_out=0; underflow_cnt increments by 1 per pulse.
- Push 16'h1234, 16'h8000, 16'h7FFF with div=4: the next three pulses, 4 cycles apart, carry those values in order. The fourth pulse holds 16'h7FFF, and underflow_cnt increases by 1.
- Push 17 samples with DEPTH=16 and no ticks (div=1000): fifo_level=16 and overflow_cnt=1. The 17th sample never appears at the output.
- Full FIFO, push coincident with tick: fifo_level stays 16, overflow_cnt is unchanged, and the popped value is the oldest sample.
- Write DIV_ADDR with 0: div_value=2 and pulses occur every 2 cycles. A write to address 32'h8 changes nothing.
- Assert areset for 1 cycle while 5 samples are queued: fifo_level=0, counters=0, div_value=DIV_RESET, and the next pulse is an underflow.

Source files
------------

// File: rtl/dac_feed_pkg.sv
// rtl/dac_feed_pkg.sv - shared types and constants for the DAC sample feeder
//
// Purpose: sample width, default register addresses, minimum divider value,
//          the signed sample type and the divider clamp helper.
// Ports:   none (package).
package dac_feed_pkg;

  localparam int          SAMPLE_W         = 16;
  localparam logic [31:0] SAMPLE_ADDR_DEF  = 32'h0000_0000;
  localparam logic [31:0] DIV_ADDR_DEF     = 32'h0000_0004;
  localparam logic [31:0] DIV_MIN          = 32'd2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // A divider below 2 would leave the tick permanently asserted or never
  // reachable, so small writes are raised to the minimum.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered level and full/empty flags
//
// Purpose: sample storage for the feeder. Pop of an empty FIFO and push into a
//          full FIFO without a simultaneous pop are ignored.
// Ports:   clk_i, rst_i      clock, synchronous active-high reset
//          push_i, wdata_i   write request and data
//          pop_i, rdata_o    read request and head-of-queue data
//          level_o           occupancy 0..DEPTH
//          full_o, empty_o   status flags derived from the level register
module sync_fifo
  import dac_feed_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A push into a full FIFO is accepted when a pop frees a slot the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; contents behind the read pointer are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - write-port sample FIFO with programmable drain tick
//
// Purpose: decodes completed AXI-Lite writes into sample pushes or divider
//          loads, and drains one sample per divider period toward the
//          modulator, counting underflows and overflows (saturating).
// Ports:   aclk, areset                  clock, synchronous active-high reset
//          wr_valid, wr_addr, wr_data    completed-write strobe and payload
//          sample_out, sample_valid      registered sample and its period pulse
//          fifo_level                    FIFO occupancy 0..DEPTH
//          underflow_cnt, overflow_cnt   saturating event counters
//          div_value                     active divider (cycles per sample)
module dac_sample_feeder
  import dac_feed_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] SAMPLE_ADDR = SAMPLE_ADDR_DEF,
  parameter logic [31:0] DIV_ADDR    = DIV_ADDR_DEF,
  parameter logic [31:0] DIV_RESET   = 32'd100
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_addr,
  input  logic [31:0]            wr_data,
  output logic [15:0]            sample_out,
  output logic                   sample_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            underflow_cnt,
  output logic [15:0]            overflow_cnt,
  output logic [31:0]            div_value
);

  sample_t     sample_q, sample_d;
  logic        valid_q, valid_d;
  logic [15:0] und_q, und_d;
  logic [15:0] ovf_q, ovf_d;
  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;

  logic        tick, push, div_wr, pop;
  logic        fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  assign push   = wr_valid && (wr_addr == SAMPLE_ADDR);
  assign div_wr = wr_valid && (wr_addr == DIV_ADDR);
  assign tick   = (cnt_q == div_q - 32'd1);
  // No bypass: a push landing on a tick with an empty FIFO is stored, not sent.
  assign pop    = tick && !fifo_empty;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push),
    .wdata_i (wr_data[SAMPLE_W-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    sample_d = sample_q;
    valid_d  = tick;
    und_d    = und_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    cnt_d    = tick ? 32'd0 : cnt_q + 32'd1;

    if (pop) sample_d = sample_t'(fifo_head);
    if (tick && fifo_empty && (und_q != 16'hFFFF)) und_d = und_q + 16'd1;
    if (push && fifo_full && !pop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;

    // A divider load restarts the period; a coincident tick has already popped.
    if (div_wr) begin
      div_d = clamp_div(wr_data);
      cnt_d = 32'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      und_q    <= '0;
      ovf_q    <= '0;
      div_q    <= DIV_RESET;
      cnt_q    <= '0;
    end else begin
      sample_q <= sample_d;
      valid_q  <= valid_d;
      und_q    <= und_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_valid  = valid_q;
  assign underflow_cnt = und_q;
  assign overflow_cnt  = ovf_q;
  assign div_value     = div_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - self-checking bench for dac_sample_feeder
module tb_dac_sample_feeder;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [4:0]  fifo_level;
  logic [15:0] underflow_cnt;
  logic [15:0] overflow_cnt;
  logic [31:0] div_value;

  dac_sample_feeder #(
    .DEPTH       (DEPTH),
    .SAMPLE_ADDR (32'h0),
    .DIV_ADDR    (32'h4),
    .DIV_RESET   (32'd100)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt),
    .overflow_cnt  (overflow_cnt),
    .div_value     (div_value)
  );

  always #5 aclk = ~aclk;

  int vecs = 0;
  int errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: queue-based FIFO plus period counter, advanced on each edge.
  int unsigned m_cnt = 0;
  int unsigned m_div = 100;
  logic [15:0] m_q[$];
  logic [15:0] m_last = '0;
  logic [15:0] exp_q[$];
  bit          m_tick;

  always @(posedge aclk) begin
    if (areset) begin
      m_cnt  = 0;
      m_div  = 100;
      m_q.delete();
      m_last = '0;
    end else begin
      m_tick = (m_cnt == m_div - 1);
      if (m_tick) begin
        if (m_q.size() != 0) m_last = m_q.pop_front();
        exp_q.push_back(m_last);
      end
      if (wr_valid && wr_addr == 32'h0 && m_q.size() < DEPTH)
        m_q.push_back(wr_data[15:0]);
      if (wr_valid && wr_addr == 32'h4) begin
        m_div = (wr_data < 2) ? 2 : wr_data;
        m_cnt = 0;
      end else begin
        m_cnt = m_tick ? 0 : m_cnt + 1;
      end
    end
  end

  // Scoreboard: every pulse must match the oldest expected sample.
  logic [15:0] exp_s;
  always @(negedge aclk) begin
    if (sample_valid || exp_q.size() != 0) begin
      check_eq("pulse", {31'd0, sample_valid}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_s = exp_q.pop_front();
        check_eq("sample", {16'd0, sample_out}, {16'd0, exp_s});
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(posedge aclk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge aclk); #1;
      n++;
    end while (!sample_valid && n < 2000);
    check_eq("pulse_wait", {31'd0, sample_valid}, 32'd1);
  endtask

  int n;

  initial begin
    idle(3);
    check_eq("rst_sample", {16'd0, sample_out}, 32'd0);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
    check_eq("rst_und", {16'd0, underflow_cnt}, 32'd0);
    check_eq("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    check_eq("rst_div", div_value, 32'd100);
    areset = 1'b0;

    // Idle: underflow pulses every DIV_RESET cycles.
    wait_pulse(n); check_eq("gap_first", n, 100);
    wait_pulse(n); check_eq("gap_idle", n, 100);
    check_eq("idle_und", {16'd0, underflow_cnt}, 32'd2);
    check_eq("idle_sample", {16'd0, sample_out}, 32'd0);

    // Three samples drained at div=4, then an underflow holds the last.
    wr(32'h0, 32'h0000_1234);
    wr(32'h0, 32'h0000_8000);
    wr(32'h0, 32'hABCD_7FFF);
    wr(32'h4, 32'd4);
    wait_pulse(n); check_eq("gap4_a", n, 4); check_eq("s1", {16'd0, sample_out}, 32'h1234);
    wait_pulse(n); check_eq("gap4_b", n, 4); check_eq("s2", {16'd0, sample_out}, 32'h8000);
    wait_pulse(n); check_eq("gap4_c", n, 4); check_eq("s3", {16'd0, sample_out}, 32'h7FFF);
    wait_pulse(n); check_eq("gap4_d", n, 4); check_eq("s4_hold", {16'd0, sample_out}, 32'h7FFF);
    check_eq("und_after4", {16'd0, underflow_cnt}, 32'd3);

    // Overflow: 17 pushes into 16 slots with no ticks.
    wr(32'h4, 32'd1000);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'h0000_A000 + i);
    idle(1);
    check_eq("full_level", {27'd0, fifo_level}, 32'd16);
    check_eq("ovf_one", {16'd0, overflow_cnt}, 32'd1);
    check_eq("div_1000", div_value, 32'd1000);

    // Push coincident with a tick on a full FIFO.
    wr(32'h4, 32'd4);
    idle(3);
    wr(32'h0, 32'h0000_BEEF);
    check_eq("coinc_valid", {31'd0, sample_valid}, 32'd1);
    check_eq("coinc_level", {27'd0, fifo_level}, 32'd16);
    check_eq("coinc_ovf", {16'd0, overflow_cnt}, 32'd1);
    check_eq("coinc_oldest", {16'd0, sample_out}, 32'hA000);

    // Divider clamp and ignored address.
    wr(32'h4, 32'd0);
    check_eq("div_clamp", div_value, 32'd2);
    wait_pulse(n); check_eq("gap2_a", n, 2);
    wait_pulse(n); check_eq("gap2_b", n, 2);
    wait_pulse(n); check_eq("gap2_c", n, 2);
    wr(32'h8, 32'd77);
    check_eq("bad_addr_div", div_value, 32'd2);
    check_eq("bad_addr_level", {27'd0, fifo_level}, m_q.size());
    check_eq("bad_addr_ovf", {16'd0, overflow_cnt}, 32'd1);
    idle(40);
    check_eq("drained", {27'd0, fifo_level}, 32'd0);

    // Mid-operation reset with 5 queued samples.
    wr(32'h4, 32'd1000);
    for (int i = 0; i < 5; i++) wr(32'h0, 32'h0000_5000 + i);
    idle(1);
    check_eq("five_level", {27'd0, fifo_level}, 32'd5);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    check_eq("mrst_level", {27'd0, fifo_level}, 32'd0);
    check_eq("mrst_und", {16'd0, underflow_cnt}, 32'd0);
    check_eq("mrst_ovf", {16'd0, overflow_cnt}, 32'd0);
    check_eq("mrst_div", div_value, 32'd100);
    check_eq("mrst_sample", {16'd0, sample_out}, 32'd0);
    wait_pulse(n); check_eq("mrst_gap", n, 100);
    check_eq("mrst_und_pulse", {16'd0, underflow_cnt}, 32'd1);
    check_eq("mrst_pulse_sample", {16'd0, sample_out}, 32'd0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
